// File: rtl/mem_stage_unit.sv
// mem_stage_unit: MEM-stage controller of the 5-stage MIPS32 pipeline.
// Runs a req/ack handshake to a variable-latency data memory.
// Holds the pipeline in stall while an access is outstanding.
// Builds byte enables and lane-replicated store data.
// Extracts and sign/zero-extends load data for reg_MEM_WB.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   valid_in              EX/MEM holds a valid instruction
//   z_in, b_in            effective address / ALU result, store data (rt)
//   mem_rd, mem_wr        load / store instruction
//   size, sign_ext        access size (00 W, 01 H, 10 B, 11 as W), load extension
//   sel4_in, reg_wr_in    WB controls from EX/MEM
//   rd_in                 destination register
//   dmem_*                registered memory request side; dmem_ack/dmem_rdata response
//   LMD, z_MEM, sel4_MEM, reg_wr_MEM, rd_MEM   values captured by reg_MEM_WB
//   stall                 freezes the upstream pipeline
//   misalign_exc          misaligned memory access this cycle (combinational)
//   bus_err               one-cycle pulse when the memory never answered
module mem_stage_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] z_in,
  input  logic [31:0] b_in,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic        sel4_in,
  input  logic        reg_wr_in,
  input  logic [4:0]  rd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] LMD,
  output logic [31:0] z_MEM,
  output logic        sel4_MEM,
  output logic        reg_wr_MEM,
  output logic [4:0]  rd_MEM,
  output logic        stall,
  output logic        misalign_exc,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t             state_q;
  logic               req_q;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [3:0]         be_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               bus_err_q;
  logic               err_q;

  logic [1:0]         off_s;
  logic               misalign_s;
  logic               mem_op_s;
  logic               access_s;
  logic [3:0]         be_s;
  logic [31:0]        wdata_s;
  logic [7:0]         byte_s;
  logic [15:0]        half_s;
  logic               load_done_s;

  assign off_s    = z_in[1:0];
  assign mem_op_s = valid_in & (mem_rd | mem_wr);
  assign access_s = mem_op_s & ~misalign_s;

  // Alignment check, byte enables and lane-replicated store data by size
  always_comb begin
    misalign_s = 1'b0;
    be_s       = 4'b1111;
    wdata_s    = b_in;
    case (size)
      2'b01: begin
        misalign_s = off_s[0];
        be_s       = off_s[1] ? 4'b1100 : 4'b0011;
        wdata_s    = {2{b_in[15:0]}};
      end
      2'b10: begin
        misalign_s = 1'b0;
        be_s       = 4'b0001 << off_s;
        wdata_s    = {4{b_in[7:0]}};
      end
      default: begin
        // word and the reserved encoding both behave as a word access
        misalign_s = (off_s != 2'b00);
        be_s       = 4'b1111;
        wdata_s    = b_in;
      end
    endcase
  end

  // Access FSM with registered request outputs, read latch and timeout counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0000_0000;
      be_q      <= 4'b0000;
      wdata_q   <= 32'h0000_0000;
      rdata_q   <= 32'h0000_0000;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (access_s) begin
            state_q <= S_WAIT;
            req_q   <= 1'b1;
            we_q    <= mem_wr;
            addr_q  <= {z_in[31:2], 2'b00};
            be_q    <= be_s;
            wdata_q <= wdata_s;
            cnt_q   <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          // an ack on the timeout cycle still completes the access normally
          if (dmem_ack) begin
            rdata_q <= dmem_rdata;
            req_q   <= 1'b0;
            state_q <= S_DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            req_q     <= 1'b0;
            bus_err_q <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Lane selection from the read latch; EX/MEM is frozen so z_in still holds the offset
  always_comb begin
    case (off_s)
      2'b00:   byte_s = rdata_q[7:0];
      2'b01:   byte_s = rdata_q[15:8];
      2'b10:   byte_s = rdata_q[23:16];
      default: byte_s = rdata_q[31:24];
    endcase
    half_s = off_s[1] ? rdata_q[31:16] : rdata_q[15:0];
  end

  assign load_done_s = (state_q == S_DONE) & mem_rd & ~mem_wr;

  // Load data extension; zero for stores, non-memory ops and outside DONE
  always_comb begin
    if (load_done_s) begin
      case (size)
        2'b10:   LMD = {{24{sign_ext & byte_s[7]}}, byte_s};
        2'b01:   LMD = {{16{sign_ext & half_s[15]}}, half_s};
        default: LMD = rdata_q;
      endcase
    end else begin
      LMD = 32'h0000_0000;
    end
  end

  assign stall        = ~reset & (((state_q == S_IDLE) & access_s) | (state_q == S_WAIT));
  assign misalign_exc = mem_op_s & misalign_s;
  assign reg_wr_MEM   = reg_wr_in & valid_in & ~misalign_s & ~err_q & ~reset & ~stall;
  assign z_MEM        = z_in;
  assign sel4_MEM     = sel4_in;
  assign rd_MEM       = rd_in;

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign bus_err    = bus_err_q;

endmodule
